// File: rtl/sigdelay_ctrl.sv
// ============================================================================
//  Module      : sigdelay_ctrl
//  Description : Circular delay-line sequencer for a dual-port sample RAM,
//                with full zero-fill after reset or on request.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sigdelay_ctrl #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [D_WIDTH-1:0] i_sample_in,
    input  logic [A_WIDTH-1:0] i_offset,
    input  logic               i_clr_req,
    output logic               o_ram_wr_en,
    output logic               o_ram_rd_en,
    output logic [A_WIDTH-1:0] o_ram_wr_addr,
    output logic [A_WIDTH-1:0] o_ram_rd_addr,
    output logic [D_WIDTH-1:0] o_ram_din,
    input  logic [D_WIDTH-1:0] i_ram_dout,
    output logic [D_WIDTH-1:0] o_delayed_out,
    output logic               o_out_valid,
    output logic               o_busy,
    output logic               o_dropped
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [A_WIDTH-1:0] C_LAST_ADDR = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [A_WIDTH-1:0]   r_clr_cnt;
    logic [A_WIDTH-1:0]   w_clr_cnt_nxt;
    logic [A_WIDTH-1:0]   r_wptr;
    logic [A_WIDTH-1:0]   w_wptr_nxt;
    logic                 r_rd_pend;
    logic                 r_out_valid;
    logic [D_WIDTH-1:0]   r_delayed_out;
    logic                 r_dropped;
    logic [A_WIDTH-1:0]   r_wr_addr_hold;
    logic [A_WIDTH-1:0]   r_rd_addr_hold;
    logic [D_WIDTH-1:0]   r_din_hold;

    logic                 w_accept;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [A_WIDTH-1:0]   w_wr_addr;
    logic [A_WIDTH-1:0]   w_rd_addr;
    logic [D_WIDTH-1:0]   w_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wptr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_wptr    <= w_wptr_nxt;
        end
    end

    // Idle RUN cycles replay the last address/data so the RAM bus stays quiet.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_wptr_nxt    = r_wptr;
        w_accept      = 1'b0;
        w_wr_en       = 1'b0;
        w_rd_en       = 1'b0;
        w_wr_addr     = r_wr_addr_hold;
        w_rd_addr     = r_rd_addr_hold;
        w_din         = r_din_hold;
        case (r_state)
            ST_CLEAR: begin
                w_wr_en       = 1'b1;
                w_wr_addr     = r_clr_cnt;
                w_din         = '0;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == C_LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_wptr_nxt  = '0;
                end
            end
            ST_RUN: begin
                if (i_en) begin
                    w_accept   = 1'b1;
                    w_wr_en    = 1'b1;
                    w_rd_en    = 1'b1;
                    w_wr_addr  = r_wptr;
                    w_rd_addr  = r_wptr - i_offset;
                    w_din      = i_sample_in;
                    w_wptr_nxt = r_wptr + 1'b1;
                end
                if (i_clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend      <= 1'b0;
            r_out_valid    <= 1'b0;
            r_delayed_out  <= '0;
            r_dropped      <= 1'b0;
            r_wr_addr_hold <= '0;
            r_rd_addr_hold <= '0;
            r_din_hold     <= '0;
        end else begin
            r_rd_pend      <= w_accept;
            r_out_valid    <= r_rd_pend;
            r_dropped      <= (r_state == ST_CLEAR) && i_en;
            r_wr_addr_hold <= w_wr_addr;
            r_rd_addr_hold <= w_rd_addr;
            r_din_hold     <= w_din;
            if (r_rd_pend) begin
                r_delayed_out <= i_ram_dout;
            end
        end
    end

    assign o_ram_wr_en   = w_wr_en & rst_n;
    assign o_ram_rd_en   = w_rd_en & rst_n;
    assign o_ram_wr_addr = w_wr_addr;
    assign o_ram_rd_addr = w_rd_addr;
    assign o_ram_din     = w_din;
    assign o_delayed_out = r_delayed_out;
    assign o_out_valid   = r_out_valid;
    assign o_busy        = (r_state == ST_CLEAR);
    assign o_dropped     = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_sigdelay_ctrl.sv
// ============================================================================
//  Module      : tb_sigdelay_ctrl
//  Description : Self-checking bench for sigdelay_ctrl with a sample-history
//                reference model and an attached read-before-write RAM.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sigdelay_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic          clr_req   = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [AW-1:0] offset    = '0;

    logic          ram_wr_en, ram_rd_en, out_valid, busy, dropped;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_din, ram_dout, delayed_out;

    always #5 clk = ~clk;

    sigdelay_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (en),
        .i_sample_in  (sample_in),
        .i_offset     (offset),
        .i_clr_req    (clr_req),
        .o_ram_wr_en  (ram_wr_en),
        .o_ram_rd_en  (ram_rd_en),
        .o_ram_wr_addr(ram_wr_addr),
        .o_ram_rd_addr(ram_rd_addr),
        .o_ram_din    (ram_din),
        .i_ram_dout   (ram_dout),
        .o_delayed_out(delayed_out),
        .o_out_valid  (out_valid),
        .o_busy       (busy),
        .o_dropped    (dropped)
    );

    // RAM starts full of non-zero garbage so a missing zero-fill shows up.
    logic [DW-1:0] mem [DEPTH];
    bit            mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(8'hA5 ^ i);
            mem_init_done <= 1'b1;
        end else begin
            if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
            if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: history of samples since the last completed clear.
    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          eq[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] obs[$];
    bit            m_busy = 1'b1;
    int            m_clr  = 0;
    bit            m_drop = 1'b0;
    int            cyc    = 0;
    int            m_n, m_d;
    exp_t          m_e;
    logic [DW-1:0] m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b1;
            m_clr  = 0;
            m_drop = 1'b0;
            eq.delete();
            hist.delete();
        end else begin
            cyc++;
            m_drop = m_busy && en;
            if (m_busy) begin
                m_clr++;
                if (m_clr == DEPTH) begin
                    m_busy = 1'b0;
                    hist.delete();
                end
            end else begin
                if (en) begin
                    m_n     = hist.size();
                    m_d     = (offset == 0) ? DEPTH : int'(offset);
                    m_e.due = cyc + 1;
                    m_e.val = (m_n >= m_d) ? hist[m_n - m_d] : '0;
                    eq.push_back(m_e);
                    hist.push_back(sample_in);
                end
                if (clr_req) begin
                    m_busy = 1'b1;
                    m_clr  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = '0;
        end else begin
            chk("busy", busy, m_busy);
            chk("dropped", dropped, m_drop);
            if (eq.size() > 0 && eq[0].due < cyc) begin
                chk("out_valid_missed", cyc, eq[0].due);
                void'(eq.pop_front());
            end
            if (eq.size() > 0 && eq[0].due == cyc) begin
                chk("out_valid", out_valid, 1);
                chk("delayed_out", delayed_out, eq[0].val);
                m_last = eq[0].val;
                obs.push_back(delayed_out);
                void'(eq.pop_front());
            end else begin
                chk("out_valid_idle", out_valid, 0);
                chk("delayed_hold", delayed_out, m_last);
            end
            if (m_busy) begin
                chk("clr_wr_en", ram_wr_en, 1);
                chk("clr_rd_en", ram_rd_en, 0);
                chk("clr_wr_addr", ram_wr_addr, m_clr);
                chk("clr_din", ram_din, 0);
            end else if (en) begin
                chk("run_wr_en", ram_wr_en, 1);
                chk("run_rd_en", ram_rd_en, 1);
                chk("run_wr_addr", ram_wr_addr, hist.size() % DEPTH);
                chk("run_rd_addr", ram_rd_addr,
                    (hist.size() % DEPTH + DEPTH - int'(offset)) % DEPTH);
                chk("run_din", ram_din, sample_in);
            end else begin
                chk("idle_wr_en", ram_wr_en, 0);
                chk("idle_rd_en", ram_rd_en, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        if (busy) chk("clear_timeout", busy, 0);
    endtask

    task automatic count_clear();
        int cnt = 0;
        @(negedge clk);
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles", cnt, DEPTH);
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_delayed"}, delayed_out, 0);
        chk({tag, "_dropped"}, dropped, 0);
        chk({tag, "_wr_en"}, ram_wr_en, 0);
        chk({tag, "_rd_en"}, ram_rd_en, 0);
    endtask

    int exp3[8] = '{0, 0, 0, 1, 2, 3, 4, 5};
    int r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        #1;
        rst_n = 1'b1;
        count_clear();

        // Offset 3 with consecutive strobes
        obs.delete();
        offset = 9'd3;
        for (int k = 1; k <= 8; k++) begin
            en = 1'b1;
            sample_in = DW'(k);
            tick();
        end
        en = 1'b0;
        repeat (4) tick();
        chk("off3_count", obs.size(), 8);
        for (int i = 0; i < 8; i++) chk("off3_seq", (obs.size() > i) ? obs[i] : -1, exp3[i]);

        // clr_req together with en, then en during the clear
        obs.delete();
        en = 1'b1; sample_in = 8'h77; clr_req = 1'b1;
        tick();
        clr_req = 1'b0; sample_in = 8'h55;
        tick();
        en = 1'b0;
        @(negedge clk);
        chk("clrreq_busy", busy, 1);
        chk("clrreq_dropped", dropped, 1);
        tick();
        tick();
        chk("clrreq_out_count", obs.size(), 1);
        chk("clrreq_out_val", (obs.size() > 0) ? obs[0] : -1, 6);
        wait_idle();

        // Offset 0: full-depth delay
        obs.delete();
        offset = '0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            en = 1'b1;
            sample_in = DW'(k % 256);
            tick();
        end
        en = 1'b0;
        repeat (4) tick();
        chk("off0_count", obs.size(), DEPTH + 1);
        chk("off0_first", (obs.size() > 0) ? obs[0] : -1, 0);
        chk("off0_512th", (obs.size() > DEPTH - 1) ? obs[DEPTH - 1] : -1, 0);
        chk("off0_513th", (obs.size() > DEPTH) ? obs[DEPTH] : -1, 1);

        // Pointer wrap: wptr is 1 here, advance to 510
        for (int k = 0; k < DEPTH - 3; k++) begin
            en = 1'b1;
            sample_in = DW'($urandom);
            offset = AW'($urandom);
            tick();
        end
        en = 1'b1; offset = 9'd5; sample_in = 8'h3C;
        @(negedge clk);
        chk("wrap_wr_addr0", ram_wr_addr, 510);
        chk("wrap_rd_addr0", ram_rd_addr, 505);
        repeat (3) tick();
        @(negedge clk);
        chk("wrap_wr_addr3", ram_wr_addr, 1);
        chk("wrap_rd_addr3", ram_rd_addr, 508);
        tick();

        // Randomized traffic with occasional clear requests
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 4) != 0;
            sample_in = DW'($urandom);
            r = int'($urandom % 8);
            offset = (r == 0) ? AW'(0) : (r == 1) ? AW'(1) : (r == 2) ? AW'(DEPTH - 1) : AW'($urandom);
            clr_req = ($urandom % 400) == 0;
            tick();
        end
        en = 1'b0; clr_req = 1'b0;
        wait_idle();
        repeat (2) tick();

        // Asynchronous reset with reads in flight
        en = 1'b1; sample_in = 8'h09; offset = 9'd1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstrun");
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Asynchronous reset mid-clear at clr_cnt 200 with a drop pending
        repeat (199) tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstclr");
        repeat (2) tick();
        rst_n = 1'b1;
        count_clear();

        for (int i = 0; i < 40; i++) begin
            en = ($urandom % 2) != 0;
            sample_in = DW'($urandom);
            offset = AW'($urandom % 4);
            tick();
        end
        en = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sigdelay_ctrl.md
# sigdelay_ctrl

Sequencing controller for the single-clock dual-port sample RAM used as a circular delay line in the signal-generator datapath. On each sample strobe it writes the incoming sample at a rolling write pointer and reads back the sample written `offset` strobes earlier, giving a programmable delay. After reset, or on request, it zero-fills the whole RAM before accepting samples.

## Interface
- `A_WIDTH`, default 9: RAM address width; depth = 2**A_WIDTH.
- `D_WIDTH`, default 8: sample width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  sample strobe, one cycle per sample.
- `sample_in`  in  D_WIDTH  sample written on `en`.
- `offset`  in  A_WIDTH  delay in samples, sampled in the `en` cycle.
- `clr_req`  in  1  request full RAM zero-fill.
- `ram_wr_en`  out  1  RAM write strobe.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_wr_addr`  out  A_WIDTH  RAM write address.
- `ram_rd_addr`  out  A_WIDTH  RAM read address.
- `ram_din`  out  D_WIDTH  RAM write data.
- `ram_dout`  in  D_WIDTH  RAM read data; registered, valid the cycle after `ram_rd_en`.
- `delayed_out`  out  D_WIDTH  delayed sample, registered.
- `out_valid`  out  1  one-cycle pulse: `delayed_out` updated.
- `busy`  out  1  high in CLEAR.
- `dropped`  out  1  one-cycle pulse: `en` arrived during CLEAR and was discarded.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with `clr_cnt`=0 and `wptr`=0.
- CLEAR, every cycle:
  - `ram_wr_en`=1, `ram_wr_addr`=`clr_cnt`, `ram_din`=0, `ram_rd_en`=0; `clr_cnt` increments.
  - After the write to address 2**A_WIDTH-1: go to RUN, `wptr`=0.
  - `en` is ignored and pulses `dropped` the next cycle. `clr_req` is ignored.
- RUN, with `en`=1:
  - `ram_wr_en`=1, `ram_wr_addr`=`wptr`, `ram_din`=`sample_in`.
  - `ram_rd_en`=1, `ram_rd_addr`=(`wptr` - `offset`) mod 2**A_WIDTH.
  - `wptr` increments and wraps from 2**A_WIDTH-1 to 0.
- RUN, with `en`=0: both strobes are 0 and the address/data outputs hold their last values.
- RUN, with `clr_req`=1: go to CLEAR next cycle with `clr_cnt`=0.
  - If `en` is high in the same cycle, that sample is still written and read first.
- RAM-side outputs are a combinational decode of state, counters and inputs. `ram_wr_en` and `ram_rd_en` are forced to 0 while `rst_n` is low.
- Address arithmetic is A_WIDTH-bit modular; no saturation.
- The RAM is read-before-write, so:
  - `offset`=0 returns the sample written 2**A_WIDTH strobes ago, or 0 if not yet written since the last clear.
  - `offset`=1 returns the previous sample.

## Timing
- Reset values: `delayed_out`=0, `out_valid`=0, `busy`=1, `dropped`=0, `wptr`=0, `clr_cnt`=0.
- Clear duration: exactly 2**A_WIDTH cycles (512 at default).
  - `busy` falls in the first cycle after the last clear write.
  - `en` in that cycle is accepted.
- Latency: `en` high in cycle N gives `ram_dout` valid in N+1.
  - `delayed_out` is registered at the end of N+1.
  - `out_valid` is high during cycle N+2 only.
- Back-to-back `en` on consecutive cycles is supported at full rate: one `out_valid` per `en`, in order.
- Asynchronous reset mid-CLEAR or mid-RUN:
  - All registers return to their reset values immediately.
  - A pending `out_valid` is cancelled.
  - Clear restarts from address 0.

## Test plan
- Reset, hold `en`=0: `busy`=1 for 512 cycles; RAM writes 0 to addresses 0..511 in order; `busy`=0 at cycle 512.
- After clear, `offset`=3, feed `en` every cycle with samples 1,2,3,...: `delayed_out` is 0,0,0,1,2,3,..., each with `out_valid` 2 cycles after its `en`.
- `offset`=0, feed 513 samples valued k mod 256: the 513th read returns sample #1's value (1); the first 512 reads return 0.
- Wrap: with `wptr`=510, `offset`=5: `ram_rd_addr`=505; after 3 strobes `wptr`=1 and `ram_rd_addr`=508.
- `clr_req` with `en` in the same RUN cycle: that sample is written, its `out_valid` still pulses, then `busy`=1; `en` during clear pulses `dropped` and causes no RAM write of `sample_in`.
- Deassert `rst_n` mid-clear at `clr_cnt`=200: outputs return to reset values asynchronously; after release, the clear restarts at address 0 and lasts 512 cycles.
